// File: rtl/stim_sweep_pkg.sv
// Shared types and helpers for the exhaustive stimulus sweeper.
// Contents: sweep state enum, MISR polynomial, hold-counter width,
// and misr_next() for one 16-bit signature step.
package stim_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned HOLD_CNT_W = 8;
  localparam logic [15:0] MISR_POLY  = 16'h1021;

  // Shift left, fold the MSB back through the polynomial, then XOR the new response into bit 0.
  function automatic logic [15:0] misr_next(input logic [15:0] sig, input logic b);
    return {sig[14:0], 1'b0} ^ (sig[15] ? MISR_POLY : 16'h0000) ^ {15'd0, b};
  endfunction

endpackage

// File: rtl/exhaustive_stim_sweep_if.sv
// Stimulus/response bundle between the sweeper (master) and the block under
// exercise plus whoever reads the results (slave).
//   start       : one-cycle sweep request (into sweeper)
//   y_in        : response Y, combinational from stim (into sweeper)
//   stim        : current vector, MSB = input A
//   stim_valid  : stim carries a sweep vector
//   busy / done : sweep running / one-cycle completion pulse
//   truth_table : bit k = Y sampled for vector k
//   ones_count  : number of vectors with Y=1
//   signature   : 16-bit response MISR (only with STIM_SWEEP_MISR_EN)
interface exhaustive_stim_sweep_if #(
  parameter int unsigned N_IN = 5
);
  localparam int unsigned VEC_CNT = 2**N_IN;

  logic               start;
  logic               y_in;
  logic [N_IN-1:0]    stim;
  logic               stim_valid;
  logic               busy;
  logic               done;
  logic [VEC_CNT-1:0] truth_table;
  logic [N_IN:0]      ones_count;
`ifdef STIM_SWEEP_MISR_EN
  logic [15:0]        signature;

  modport master (input start, input y_in, output stim, output stim_valid, output busy,
                  output done, output truth_table, output ones_count, output signature);
  modport slave  (output start, output y_in, input stim, input stim_valid, input busy,
                  input done, input truth_table, input ones_count, input signature);
`else
  modport master (input start, input y_in, output stim, output stim_valid, output busy,
                  output done, output truth_table, output ones_count);
  modport slave  (output start, output y_in, input stim, input stim_valid, input busy,
                  input done, input truth_table, input ones_count);
`endif

endinterface

// File: rtl/stim_misr16.sv
// 16-bit response signature register (MISR, polynomial 0x1021).
//   clk, rst_n : clock, synchronous active-low reset
//   i_clr      : clear signature to 0x0000 (wins over i_en)
//   i_en       : fold i_bit into the signature this cycle
//   i_bit      : response bit
//   o_sig      : current signature
module stim_misr16
  import stim_sweep_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clr,
  input  logic        i_en,
  input  logic        i_bit,
  output logic [15:0] o_sig
);

  logic [15:0] r_sig;

  always_ff @(posedge clk) begin
    if (!rst_n)     r_sig <= 16'h0000;
    else if (i_clr) r_sig <= 16'h0000;
    else if (i_en)  r_sig <= misr_next(r_sig, i_bit);
  end

  assign o_sig = r_sig;

endmodule

// File: rtl/exhaustive_stim_sweep.sv
// Exhaustive stimulus sequencer: on start, drives every N_IN-bit vector in
// ascending order, holds each for HOLD cycles, samples Y on the last hold
// cycle and builds a truth table plus ones count.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : exhaustive_stim_sweep_if.master (start, y_in in; stim,
//                stim_valid, busy, done, truth_table, ones_count out)
// Optional: STIM_SWEEP_MISR_EN adds bus.signature, a 16-bit MISR of the
// sampled responses.
module exhaustive_stim_sweep
  import stim_sweep_pkg::*;
#(
  parameter int unsigned N_IN = 5,
  parameter int unsigned HOLD = 1
) (
  input logic                    clk,
  input logic                    rst_n,
  exhaustive_stim_sweep_if.master bus
);

  localparam int unsigned VEC_CNT = 2**N_IN;
  localparam int unsigned CNT_W   = N_IN + 1;

  state_e                  r_state;
  state_e                  w_state_nxt;
  logic [N_IN-1:0]         r_idx;
  logic [N_IN-1:0]         w_idx_nxt;
  logic [HOLD_CNT_W-1:0]   r_hold;
  logic [HOLD_CNT_W-1:0]   w_hold_nxt;
  logic [VEC_CNT-1:0]      r_tt;
  logic [VEC_CNT-1:0]      w_tt_nxt;
  logic [CNT_W-1:0]        r_ones;
  logic [CNT_W-1:0]        w_ones_nxt;
  logic                    r_valid;
  logic                    w_valid_nxt;
  logic                    r_busy;
  logic                    w_busy_nxt;
  logic                    r_done;
  logic                    w_done_nxt;

  logic w_accept;
  logic w_capture;
  logic w_last_vec;

  assign w_accept   = (r_state == IDLE) && bus.start;
  assign w_capture  = (r_state == RUN) && (r_hold == HOLD_CNT_W'(HOLD - 1));
  assign w_last_vec = (r_idx == N_IN'(VEC_CNT - 1));

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_state_nxt = RUN;
      RUN:     if (w_capture && w_last_vec) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath; stim is r_idx, so idx returns to 0 on completion.
  always_comb begin
    w_idx_nxt   = r_idx;
    w_hold_nxt  = r_hold;
    w_tt_nxt    = r_tt;
    w_ones_nxt  = r_ones;
    w_valid_nxt = (w_state_nxt == RUN);
    w_busy_nxt  = (w_state_nxt == RUN);
    w_done_nxt  = (w_state_nxt == DONE);
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_idx_nxt  = '0;
          w_hold_nxt = '0;
          w_tt_nxt   = '0;
          w_ones_nxt = '0;
        end
      end
      RUN: begin
        if (w_capture) begin
          w_tt_nxt[r_idx] = bus.y_in;
          w_ones_nxt      = r_ones + CNT_W'(bus.y_in);
          w_hold_nxt      = '0;
          w_idx_nxt       = w_last_vec ? '0 : r_idx + N_IN'(1);
        end else begin
          w_hold_nxt = r_hold + HOLD_CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Datapath / output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idx   <= '0;
      r_hold  <= '0;
      r_tt    <= '0;
      r_ones  <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_idx   <= w_idx_nxt;
      r_hold  <= w_hold_nxt;
      r_tt    <= w_tt_nxt;
      r_ones  <= w_ones_nxt;
      r_valid <= w_valid_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign bus.stim        = r_idx;
  assign bus.stim_valid  = r_valid;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.truth_table = r_tt;
  assign bus.ones_count  = r_ones;

`ifdef STIM_SWEEP_MISR_EN
  logic [15:0] w_sig;

  stim_misr16 u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_accept),
    .i_en  (w_capture),
    .i_bit (bus.y_in),
    .o_sig (w_sig)
  );

  assign bus.signature = w_sig;
`endif

endmodule

// File: tb/tb_exhaustive_stim_sweep.sv
// Bench for exhaustive_stim_sweep: two instances (HOLD=1, HOLD=3), N_IN=5,
// Y generated from stim by a selectable rule; results compared with a
// truth-table model computed directly from the rule.
module tb_exhaustive_stim_sweep;

  logic clk;
  logic rst_n;

  int          mode1, mode3;
  logic [31:0] tbl1, tbl3;
  int          n_chk, n_pass;

  exhaustive_stim_sweep_if #(.N_IN(5)) bus_h1 ();
  exhaustive_stim_sweep_if #(.N_IN(5)) bus_h3 ();

  exhaustive_stim_sweep #(.N_IN(5), .HOLD(1)) u_dut_h1 (.clk(clk), .rst_n(rst_n), .bus(bus_h1));
  exhaustive_stim_sweep #(.N_IN(5), .HOLD(3)) u_dut_h3 (.clk(clk), .rst_n(rst_n), .bus(bus_h3));

  // Y rules: 0 zero, 1 E, 2 A&B, 3 parity, 4 lookup table, 5 one
  function automatic logic y_func(input int mode, input logic [31:0] tbl, input logic [4:0] v);
    case (mode)
      1:       return v[0];
      2:       return v[4] & v[3];
      3:       return ^v;
      4:       return tbl[v];
      5:       return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  assign bus_h1.y_in = y_func(mode1, tbl1, bus_h1.stim);
  assign bus_h3.y_in = y_func(mode3, tbl3, bus_h3.stim);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [4:0]  get_stim (input int w); return (w == 1) ? bus_h1.stim        : bus_h3.stim;        endfunction
  function automatic logic        get_valid(input int w); return (w == 1) ? bus_h1.stim_valid  : bus_h3.stim_valid;  endfunction
  function automatic logic        get_busy (input int w); return (w == 1) ? bus_h1.busy        : bus_h3.busy;        endfunction
  function automatic logic        get_done (input int w); return (w == 1) ? bus_h1.done        : bus_h3.done;        endfunction
  function automatic logic [31:0] get_tt   (input int w); return (w == 1) ? bus_h1.truth_table : bus_h3.truth_table; endfunction
  function automatic logic [5:0]  get_ones (input int w); return (w == 1) ? bus_h1.ones_count  : bus_h3.ones_count;  endfunction
`ifdef STIM_SWEEP_MISR_EN
  function automatic logic [15:0] get_sig  (input int w); return (w == 1) ? bus_h1.signature   : bus_h3.signature;   endfunction
`endif

  task automatic set_start(input int w, input logic v);
    if (w == 1) bus_h1.start = v;
    else        bus_h3.start = v;
  endtask

  task automatic check_idle_zero(input int w, input string tag);
    chk({tag, "_stim"},  64'(get_stim(w)),  64'd0);
    chk({tag, "_valid"}, 64'(get_valid(w)), 64'd0);
    chk({tag, "_busy"},  64'(get_busy(w)),  64'd0);
    chk({tag, "_done"},  64'(get_done(w)),  64'd0);
    chk({tag, "_tt"},    64'(get_tt(w)),    64'd0);
    chk({tag, "_ones"},  64'(get_ones(w)),  64'd0);
`ifdef STIM_SWEEP_MISR_EN
    chk({tag, "_sig"},   64'(get_sig(w)),   64'd0);
`endif
  endtask

  // One full sweep on instance w; poke re-pulses start during RUN and DONE.
  task automatic sweep(input int w, input int mode, input logic [31:0] tbl, input bit poke);
    int          hold;
    int          n;
    logic [31:0] exp_tt;
    int          exp_ones;
    logic [15:0] exp_sig;
    logic        yb;
    hold = (w == 1) ? 1 : 3;
    n    = 32 * hold;
    if (w == 1) begin mode1 = mode; tbl1 = tbl; end
    else        begin mode3 = mode; tbl3 = tbl; end
    exp_tt  = '0;
    exp_sig = 16'h0000;
    for (int k = 0; k < 32; k++) begin
      yb        = y_func(mode, tbl, 5'(k));
      exp_tt[k] = yb;
      exp_sig   = {exp_sig[14:0], 1'b0} ^ (exp_sig[15] ? 16'h1021 : 16'h0000) ^ {15'd0, yb};
    end
    exp_ones = $countones(exp_tt);

    @(negedge clk); set_start(w, 1'b1);
    @(negedge clk); set_start(w, 1'b0);
    for (int c = 1; c <= n; c++) begin
      if (c > 1) @(negedge clk);
      chk("run_stim",  64'(get_stim(w)),  64'((c - 1) / hold));
      chk("run_valid", 64'(get_valid(w)), 64'd1);
      chk("run_busy",  64'(get_busy(w)),  64'd1);
      chk("run_done",  64'(get_done(w)),  64'd0);
      if (poke && (c == 5 || c == 20)) set_start(w, 1'b1);
      if (poke && (c == 6 || c == 21)) set_start(w, 1'b0);
    end
    @(negedge clk);
    chk("done_pulse", 64'(get_done(w)),  64'd1);
    chk("done_valid", 64'(get_valid(w)), 64'd0);
    chk("done_stim",  64'(get_stim(w)),  64'd0);
    chk("done_busy",  64'(get_busy(w)),  64'd0);
    chk("done_tt",    64'(get_tt(w)),    64'(exp_tt));
    chk("done_ones",  64'(get_ones(w)),  64'(exp_ones));
`ifdef STIM_SWEEP_MISR_EN
    chk("done_sig",   64'(get_sig(w)),   64'(exp_sig));
`endif
    if (poke) set_start(w, 1'b1);
    @(negedge clk);
    set_start(w, 1'b0);
    chk("post_done",  64'(get_done(w)),  64'd0);
    chk("post_busy",  64'(get_busy(w)),  64'd0);
    chk("post_valid", 64'(get_valid(w)), 64'd0);
    chk("hold_tt",    64'(get_tt(w)),    64'(exp_tt));
    chk("hold_ones",  64'(get_ones(w)),  64'(exp_ones));
    @(negedge clk);
    chk("idle_busy",  64'(get_busy(w)),  64'd0);
    chk("idle_tt",    64'(get_tt(w)),    64'(exp_tt));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0; n_pass = 0;
    mode1 = 0; mode3 = 0; tbl1 = '0; tbl3 = '0;
    rst_n = 1'b0;
    bus_h1.start = 1'b0;
    bus_h3.start = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_zero(1, "rst_h1");
    check_idle_zero(3, "rst_h3");
    rst_n = 1'b1;
    @(negedge clk);

    sweep(1, 0, 32'h0, 1'b0);
    chk("zero_tt", 64'(get_tt(1)), 64'h0000_0000);
    sweep(1, 1, 32'h0, 1'b0);
    chk("e_tt",    64'(get_tt(1)), 64'hAAAA_AAAA);
    chk("e_ones",  64'(get_ones(1)), 64'd16);
    sweep(1, 2, 32'h0, 1'b0);
    chk("ab_tt",   64'(get_tt(1)), 64'hFF00_0000);
    chk("ab_ones", 64'(get_ones(1)), 64'd8);
    sweep(3, 3, 32'h0, 1'b0);
    chk("par_tt",  64'(get_tt(3)), 64'h9669_6996);
    chk("par_ones", 64'(get_ones(3)), 64'd16);

    sweep(1, 4, $urandom, 1'b1);

    // Reset mid-sweep discards partial results.
    mode1 = 4; tbl1 = $urandom | 32'h0000_0FFF;
    @(negedge clk); bus_h1.start = 1'b1;
    @(negedge clk); bus_h1.start = 1'b0;
    repeat (11) @(negedge clk);
    chk("mid_busy", 64'(get_busy(1)), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check_idle_zero(1, "midrst");
    rst_n = 1'b1;
    @(negedge clk);
    sweep(1, 4, tbl1, 1'b0);

    for (int i = 0; i < 4; i++) begin
      sweep((i % 2 == 0) ? 3 : 1, 4, $urandom, ($urandom_range(0, 1) == 1));
    end

    sweep(1, 5, 32'h0, 1'b0);
    chk("one_ones", 64'(get_ones(1)), 64'd32);
    sweep(3, 5, 32'h0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
